sram_ctrl_pipe_if: RTL and testbench
====================================

Name: sram_ctrl_pipe_if

Overview:
Parametrised successor to the single-outstanding AHB-to-SRAM control interface. It holds an inferred DEPTH x DWIDTH memory with byte-lane writes and supports 32- or 64-bit data and 1- or 2-cycle read latency. It accepts back-to-back requests on the acknowledge cycle and flags out-of-range addresses with an error. It sits between the AHB slave front end and the embedded SRAM, in place of the fixed 32-bit controller.

Parameters:
DWIDTH, 32, data width; 32 or 64 only.
AWIDTH, 20, byte-address width.
DEPTH, 512, number of DWIDTH-wide words.
RD_LATENCY, 1, memory read latency in cycles; 1 or 2.

Ports:
HCLK  in  1  clock; all logic on rising edge.
HRESETN  in  1  asynchronous active-low reset.
ahbsram_req  in  1  request; held by master until accepted.
ahbsram_write  in  1  1 = write, 0 = read; valid with req.
ahbsram_size  in  3  0 byte, 1 half, 2 word, 3 dword.
ahbsram_addr  in  AWIDTH  byte address.
ahbsram_wdata  in  DWIDTH  write data, lane-aligned (byte k on bits 8k+7:8k).
mem_busy  in  1  external stall (e.g. SRAM init or ECC scrub).
sram_ready  out  1  request can be accepted this cycle.
sramahb_ack  out  1  one-cycle completion pulse.
sramahb_err  out  1  valid with ack; 1 = address out of range.
sramahb_rdata  out  DWIDTH  read data; valid with ack for reads.
BUSY  out  1  transfer in flight or mem_busy high.

Behaviour:
- Reset values: sram_ready 0 while HRESETN low, then 1; ack 0; err 0; rdata 0; FSM in S_IDLE. Memory contents are not reset.
- Accept condition: ahbsram_req && sram_ready. sram_ready = (state == S_IDLE || sramahb_ack) && !mem_busy.
- Word index = addr[AWIDTH-1 : log2(DWIDTH/8)]. If index >= DEPTH, the access is out of range.
- Lane enables:
  - Effective size = min(size, log2(DWIDTH/8)). Size 3 with DWIDTH=32 acts as word.
  - Address bits below the effective size are ignored (force-aligned).
  - Enable 2^size consecutive lanes starting at the aligned lane offset.
- FSM states:
  - S_IDLE: on accept go to S_WR (write) or S_RD (read).
  - S_WR: ack in this cycle (accept+1). Memory is written at the accept edge, enabled lanes only.
  - S_RD: if RD_LATENCY=1, ack with rdata in this cycle (accept+1). If RD_LATENCY=2, go to S_RD2 and ack there (accept+2).
  - Ack cycle: a new accept moves directly to S_WR or S_RD (back-to-back). Otherwise return to S_IDLE.
- Reads always return the full word. Unselected lanes are not masked; the front end extracts bytes.
- Out of range: no memory write, no read strobe. Ack with err=1 at the cycle a valid access of the same type would ack. rdata = 0 for an errored read.
- Read-after-write to the same word on back-to-back requests returns the newly written data, including partial-lane merge.
- mem_busy:
  - Blocks new accepts only.
  - An in-flight transfer still completes.
  - mem_busy rising in the ack cycle blocks the back-to-back accept.
- BUSY = (state != S_IDLE) || mem_busy.
- rdata holds its last value between reads. Write acks do not change rdata.
- Reset asserted mid-transfer: the transfer is aborted, no ack is issued, and a write in progress may or may not have landed. Outputs go to reset values asynchronously.
- Exactly one outstanding transfer. Throughput is one transfer per cycle for writes and for reads with RD_LATENCY=1.

Test Plan:
1. DWIDTH=32: write word 0xDEADBEEF @0x10, then read @0x10 -> write ack at accept+1; read ack at accept+1 with rdata=0xDEADBEEF, err=0.
2. Write byte 0xAA @0x13, then half 0x5566 @0x10 over word 0x00000000 -> read @0x10 returns 0xAA005566. Half write @0x11 is force-aligned to lanes 0-1.
3. Back-to-back: req held high with write @0x20=0x11111111 then read @0x20 -> acks on consecutive cycles, read rdata=0x11111111, sram_ready never low between them.
4. DEPTH=512, DWIDTH=32: read @0x800 (index 512) -> ack+err at accept+1, rdata=0. Write @0x800 -> err=1, and index 0 is unchanged.
5. DWIDTH=64, RD_LATENCY=2: dword write 0x0123456789ABCDEF @0x8, then read @0x8 -> ack at accept+2 with matching data. BUSY is high for 2 cycles.
6. mem_busy high during a read's S_RD with req pending -> read acks normally. The next accept occurs the cycle after mem_busy falls. HRESETN pulsed mid-read -> no ack, rdata=0.

Source files
------------

// File: rtl/sram_ctrl_pipe_if.sv
// AHB-side SRAM controller: DEPTH x DWIDTH inferred memory with byte-lane writes,
// 1- or 2-cycle read latency, one transfer outstanding, back-to-back accepts on ack.
module sram_ctrl_pipe_if #(
   parameter int DWIDTH     = 32,
   parameter int AWIDTH     = 20,
   parameter int DEPTH      = 512,
   parameter int RD_LATENCY = 1
) (
   input  logic              HCLK,
   input  logic              HRESETN,
   input  logic              ahbsram_req,
   input  logic              ahbsram_write,
   input  logic [2:0]        ahbsram_size,
   input  logic [AWIDTH-1:0] ahbsram_addr,
   input  logic [DWIDTH-1:0] ahbsram_wdata,
   input  logic              mem_busy,
   output logic              sram_ready,
   output logic              sramahb_ack,
   output logic              sramahb_err,
   output logic [DWIDTH-1:0] sramahb_rdata,
   output logic              BUSY
);
   localparam int LANES     = DWIDTH / 8;
   localparam int LANE_BITS = $clog2(LANES);
   localparam int IDX_W     = AWIDTH - LANE_BITS;
   localparam int MEM_AW    = $clog2(DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_WR, S_RD, S_RD2} state_t;

   state_t               state;
   logic [DWIDTH-1:0]    mem [DEPTH];
   logic [IDX_W-1:0]     idx;
   logic [MEM_AW-1:0]    mem_idx;
   logic                 in_range;
   logic                 accept;
   logic                 wr_en;
   logic [LANE_BITS-1:0] lane_off;
   logic [2:0]           eff_size;
   logic [LANES-1:0]     lane_en;
   logic [DWIDTH-1:0]    rd_q;
   logic                 rd_err_q;

   assign idx        = ahbsram_addr[AWIDTH-1:LANE_BITS];
   assign mem_idx    = idx[MEM_AW-1:0];
   assign in_range   = idx < IDX_W'(DEPTH);
   assign lane_off   = ahbsram_addr[LANE_BITS-1:0];
   assign sram_ready = HRESETN && (state == S_IDLE || sramahb_ack) && !mem_busy;
   assign accept     = ahbsram_req && sram_ready;
   assign wr_en      = accept && ahbsram_write && in_range;
   assign BUSY       = (state != S_IDLE) || mem_busy;

   // A lane is enabled when it shares all offset bits above the (clamped) size with
   // the request address, which also force-aligns misaligned accesses.
   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      lane_en  = '0;
      eff_size = (ahbsram_size > 3'(LANE_BITS)) ? 3'(LANE_BITS) : ahbsram_size;
      for (int k = 0; k < LANES; k++) begin
         lane_en[k] = ((LANE_BITS'(k) ^ lane_off) >> eff_size) == '0;
      end
   end

   // NOTE: the array is deliberately not reset; reset leaves contents untouched and
   // keeps the array mappable onto an SRAM macro.
   always_ff @(posedge HCLK) begin
      for (int k = 0; k < LANES; k++) begin
         if (wr_en && lane_en[k]) begin
            mem[mem_idx][8*k +: 8] <= ahbsram_wdata[8*k +: 8];
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge HCLK or negedge HRESETN) begin
      if (!HRESETN) begin
         state         <= S_IDLE;
         sramahb_ack   <= 1'b0;
         sramahb_err   <= 1'b0;
         sramahb_rdata <= '0;
         rd_q          <= '0;
         rd_err_q      <= 1'b0;
      end else begin
         sramahb_ack <= 1'b0;
         sramahb_err <= 1'b0;
         if (accept) begin
            if (ahbsram_write) begin
               state       <= S_WR;
               sramahb_ack <= 1'b1;
               sramahb_err <= !in_range;
            end else begin
               state <= S_RD;
               if (RD_LATENCY == 1) begin
                  sramahb_ack   <= 1'b1;
                  sramahb_err   <= !in_range;
                  sramahb_rdata <= in_range ? mem[mem_idx] : '0;
               end else begin
                  rd_err_q <= !in_range;
                  rd_q     <= in_range ? mem[mem_idx] : '0;
               end
            end
         end else if (state == S_RD && RD_LATENCY == 2) begin
            // Second read stage: present the registered memory word with the ack.
            state         <= S_RD2;
            sramahb_ack   <= 1'b1;
            sramahb_err   <= rd_err_q;
            sramahb_rdata <= rd_q;
         end else begin
            state <= S_IDLE;
         end
      end
   end

endmodule

// File: tb/tb_sram_ctrl_pipe_if.sv
// Scoreboard bench for sram_ctrl_pipe_if: a 32-bit/1-cycle and a 64-bit/2-cycle instance
// driven with directed vectors; monitors pop expected acks and compare them.
module tb_sram_ctrl_pipe_if;
   logic HCLK = 1'b0;
   logic HRESETN;
   always #5 HCLK = ~HCLK;

   logic        req32, wr32, mbusy32, ready32, ack32, err32, busy32;
   logic [2:0]  size32;
   logic [19:0] addr32;
   logic [31:0] wdata32, rdata32;

   logic        req64, wr64, mbusy64, ready64, ack64, err64, busy64;
   logic [2:0]  size64;
   logic [19:0] addr64;
   logic [63:0] wdata64, rdata64;

   sram_ctrl_pipe_if #(.DWIDTH(32), .AWIDTH(20), .DEPTH(512), .RD_LATENCY(1)) dut32 (
      .HCLK(HCLK), .HRESETN(HRESETN), .ahbsram_req(req32), .ahbsram_write(wr32),
      .ahbsram_size(size32), .ahbsram_addr(addr32), .ahbsram_wdata(wdata32),
      .mem_busy(mbusy32), .sram_ready(ready32), .sramahb_ack(ack32), .sramahb_err(err32),
      .sramahb_rdata(rdata32), .BUSY(busy32));

   sram_ctrl_pipe_if #(.DWIDTH(64), .AWIDTH(20), .DEPTH(512), .RD_LATENCY(2)) dut64 (
      .HCLK(HCLK), .HRESETN(HRESETN), .ahbsram_req(req64), .ahbsram_write(wr64),
      .ahbsram_size(size64), .ahbsram_addr(addr64), .ahbsram_wdata(wdata64),
      .mem_busy(mbusy64), .sram_ready(ready64), .sramahb_ack(ack64), .sramahb_err(err64),
      .sramahb_rdata(rdata64), .BUSY(busy64));

   typedef struct {
      int          cyc;
      logic        err;
      logic [63:0] rdata;
   } exp_t;

   exp_t        q32[$];
   exp_t        q64[$];
   int          cyc = 0;
   int          n_cmp = 0;
   int          n_bad = 0;
   logic [63:0] last_rd32 = 64'h0;
   logic [63:0] last_rd64 = 64'h0;

   always @(posedge HCLK) cyc++;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(negedge HCLK) begin
      exp_t e;
      if (ack32 === 1'b1) begin
         if (q32.size() == 0) begin
            check("ack32_unexpected", 64'(ack32), 64'h0);
         end else begin
            e = q32.pop_front();
            check("ack32_cycle", 64'(cyc), 64'(e.cyc));
            check("err32", 64'(err32), 64'(e.err));
            check("rdata32", 64'(rdata32), e.rdata);
         end
      end
   end

   always @(negedge HCLK) begin
      exp_t e;
      if (ack64 === 1'b1) begin
         if (q64.size() == 0) begin
            check("ack64_unexpected", 64'(ack64), 64'h0);
         end else begin
            e = q64.pop_front();
            check("ack64_cycle", 64'(cyc), 64'(e.cyc));
            check("err64", 64'(err64), 64'(e.err));
            check("rdata64", rdata64, e.rdata);
         end
      end
   end

   task automatic idle(input bit d64);
      if (d64) req64 = 1'b0;
      else req32 = 1'b0;
      @(posedge HCLK);
      #1;
   endtask

   // Holds a request until accepted, then queues the expected ack; returns #1 after
   // the accept edge with req still high so a following call is back-to-back.
   task automatic issue(input bit d64, input bit write, input logic [2:0] size,
                        input logic [19:0] addr, input logic [63:0] wdata,
                        input logic [63:0] exp_rd, input bit exp_err, input bit push,
                        output int waits);
      exp_t e;
      logic rdy;
      waits = 0;
      if (d64) begin
         req64 = 1'b1; wr64 = write; size64 = size; addr64 = addr; wdata64 = wdata;
      end else begin
         req32 = 1'b1; wr32 = write; size32 = size; addr32 = addr; wdata32 = wdata[31:0];
      end
      forever begin
         @(negedge HCLK);
         rdy = d64 ? ready64 : ready32;
         if (rdy === 1'b1 || waits == 50) break;
         waits++;
      end
      if (rdy !== 1'b1) begin
         check("accept_timeout", 64'(rdy), 64'h1);
         idle(d64);
         return;
      end
      e.err = exp_err;
      if (write) begin
         e.cyc   = cyc + 1;
         e.rdata = d64 ? last_rd64 : last_rd32;
      end else begin
         e.cyc   = cyc + (d64 ? 2 : 1);
         e.rdata = exp_err ? 64'h0 : exp_rd;
      end
      if (push) begin
         if (d64) begin
            q64.push_back(e);
            if (!write) last_rd64 = e.rdata;
         end else begin
            q32.push_back(e);
            if (!write) last_rd32 = e.rdata;
         end
      end
      @(posedge HCLK);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, required the run to finish first");
      $fatal(1, "watchdog");
   end

   initial begin
      int w;
      int n;
      HRESETN = 1'b0;
      req32 = 1'b0; wr32 = 1'b0; size32 = 3'd0; addr32 = 20'h0; wdata32 = 32'h0; mbusy32 = 1'b0;
      req64 = 1'b0; wr64 = 1'b0; size64 = 3'd0; addr64 = 20'h0; wdata64 = 64'h0; mbusy64 = 1'b0;
      repeat (2) @(negedge HCLK);
      check("rst_ready32", 64'(ready32), 64'h0);
      check("rst_ack32", 64'(ack32), 64'h0);
      check("rst_err32", 64'(err32), 64'h0);
      check("rst_rdata32", 64'(rdata32), 64'h0);
      check("rst_ready64", 64'(ready64), 64'h0);
      check("rst_rdata64", rdata64, 64'h0);
      @(posedge HCLK);
      #1 HRESETN = 1'b1;
      @(negedge HCLK);
      check("ready32_after_rst", 64'(ready32), 64'h1);
      check("ready64_after_rst", 64'(ready64), 64'h1);
      check("busy32_idle", 64'(busy32), 64'h0);
      @(posedge HCLK);
      #1;

      // Word write then read, separated by an idle cycle.
      issue(1'b0, 1'b1, 3'd2, 20'h10, 64'hDEADBEEF, 64'h0, 1'b0, 1'b1, w);
      idle(1'b0);
      issue(1'b0, 1'b0, 3'd2, 20'h10, 64'h0, 64'hDEADBEEF, 1'b0, 1'b1, w);
      idle(1'b0);

      // Partial-lane merge, back-to-back, with a misaligned half forced to lanes 0-1.
      issue(1'b0, 1'b1, 3'd2, 20'h10, 64'h00000000, 64'h0, 1'b0, 1'b1, w);
      issue(1'b0, 1'b1, 3'd0, 20'h13, 64'hAA000000, 64'h0, 1'b0, 1'b1, w);
      issue(1'b0, 1'b1, 3'd1, 20'h11, 64'h00005566, 64'h0, 1'b0, 1'b1, w);
      issue(1'b0, 1'b0, 3'd2, 20'h10, 64'h0, 64'hAA005566, 1'b0, 1'b1, w);
      // Size 3 on a 32-bit bus acts as a word; then an upper-half write.
      issue(1'b0, 1'b1, 3'd3, 20'h34, 64'hCAFEF00D, 64'h0, 1'b0, 1'b1, w);
      issue(1'b0, 1'b1, 3'd1, 20'h36, 64'hBEEF0000, 64'h0, 1'b0, 1'b1, w);
      issue(1'b0, 1'b0, 3'd2, 20'h34, 64'h0, 64'hBEEFF00D, 1'b0, 1'b1, w);
      idle(1'b0);

      // Held req: write then read of the same word on consecutive cycles.
      issue(1'b0, 1'b1, 3'd2, 20'h20, 64'h11111111, 64'h0, 1'b0, 1'b1, w);
      issue(1'b0, 1'b0, 3'd2, 20'h20, 64'h0, 64'h11111111, 1'b0, 1'b1, w);
      check("b2b_ready_waits", 64'(w), 64'h0);
      idle(1'b0);

      // Out of range at index 512: errored read, errored write must not alias index 0.
      issue(1'b0, 1'b1, 3'd2, 20'h0, 64'h12345678, 64'h0, 1'b0, 1'b1, w);
      idle(1'b0);
      issue(1'b0, 1'b0, 3'd2, 20'h800, 64'h0, 64'h0, 1'b1, 1'b1, w);
      issue(1'b0, 1'b1, 3'd2, 20'h800, 64'hFFFFFFFF, 64'h0, 1'b1, 1'b1, w);
      issue(1'b0, 1'b0, 3'd2, 20'h0, 64'h0, 64'h12345678, 1'b0, 1'b1, w);
      idle(1'b0);

      // 64-bit, 2-cycle reads.
      issue(1'b1, 1'b0, 3'd3, 20'h1000, 64'h0, 64'h0, 1'b1, 1'b1, w);
      idle(1'b1);
      issue(1'b1, 1'b1, 3'd3, 20'h8, 64'h0123456789ABCDEF, 64'h0, 1'b0, 1'b1, w);
      idle(1'b1);
      issue(1'b1, 1'b0, 3'd3, 20'h8, 64'h0, 64'h0123456789ABCDEF, 1'b0, 1'b1, w);
      req64 = 1'b0;
      n = 0;
      repeat (4) begin
         @(negedge HCLK);
         if (busy64 === 1'b1) n++;
      end
      check("busy64_cycles", 64'(n), 64'h2);
      @(posedge HCLK);
      #1;
      issue(1'b1, 1'b1, 3'd2, 20'hC, 64'h55667788_00000000, 64'h0, 1'b0, 1'b1, w);
      issue(1'b1, 1'b0, 3'd3, 20'h8, 64'h0, 64'h55667788_89ABCDEF, 1'b0, 1'b1, w);
      issue(1'b1, 1'b0, 3'd2, 20'hC, 64'h0, 64'h55667788_89ABCDEF, 1'b0, 1'b1, w);
      idle(1'b1);

      // mem_busy raised in the read's ack cycle blocks the pending request.
      issue(1'b0, 1'b0, 3'd2, 20'h10, 64'h0, 64'hAA005566, 1'b0, 1'b1, w);
      mbusy32 = 1'b1;
      fork
         begin
            @(posedge HCLK);
            @(negedge HCLK);
            check("busy32_from_mem_busy", 64'(busy32), 64'h1);
            @(posedge HCLK);
            @(posedge HCLK);
            #1 mbusy32 = 1'b0;
         end
      join_none
      issue(1'b0, 1'b0, 3'd2, 20'h20, 64'h0, 64'h11111111, 1'b0, 1'b1, w);
      check("mem_busy_waits", 64'(w), 64'h3);
      idle(1'b0);

      // Reset pulsed during a 2-cycle read: no ack, outputs cleared.
      issue(1'b1, 1'b0, 3'd3, 20'h8, 64'h0, 64'h0, 1'b0, 1'b0, w);
      req64 = 1'b0;
      HRESETN = 1'b0;
      #1;
      check("rst_mid_ack64", 64'(ack64), 64'h0);
      check("rst_mid_rdata64", rdata64, 64'h0);
      check("rst_mid_ready64", 64'(ready64), 64'h0);
      repeat (2) @(negedge HCLK);
      @(posedge HCLK);
      #1 HRESETN = 1'b1;
      last_rd32 = 64'h0;
      last_rd64 = 64'h0;
      repeat (4) @(negedge HCLK);
      check("rdata64_after_abort", rdata64, 64'h0);
      @(posedge HCLK);
      #1;
      issue(1'b1, 1'b0, 3'd3, 20'h8, 64'h0, 64'h55667788_89ABCDEF, 1'b0, 1'b1, w);
      idle(1'b1);

      repeat (5) @(negedge HCLK);
      check("q32_drained", 64'(q32.size()), 64'h0);
      check("q64_drained", 64'(q64.size()), 64'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
